// File: rtl/wb_line_axi_responder_pkg.sv
// ---------------------------------------------------------------------------
// wb_line_axi_responder_pkg
//   Shared types and constants for the write-back line responder: the FSM
//   state encoding, AXI response codes, the only legal burst type, and an
//   address-window check used when an AW is accepted.
// ---------------------------------------------------------------------------
package wb_line_axi_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   // The window is tested as (addr - base) < span so that a window that
   // ends exactly at the top of the address space cannot overflow.
   function automatic logic in_range(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

endpackage

// File: rtl/wb_line_axi_responder.sv
// ---------------------------------------------------------------------------
// wb_line_axi_responder
//   Memory-side AXI4 write responder for the dcache writeback path. Accepts
//   one AW + W burst at a time, writes each beat into a word-addressed SRAM
//   port and returns a B response carrying the AW ID.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   aw_valid_i/aw_ready_o         AW handshake
//   aw_id_i/addr_i/len_i/size_i/burst_i   AW payload
//   w_valid_i/w_ready_o           W handshake
//   w_data_i/w_strb_i/w_last_i    W payload
//   b_valid_o/b_ready_i           B handshake
//   b_id_o/b_resp_o               B payload
//   mem_req_o                     SRAM write strobe (single cycle, always accepted)
//   mem_addr_o/mem_wdata_o/mem_be_o   SRAM word index, data, byte enables
// ---------------------------------------------------------------------------
module wb_line_axi_responder
   import wb_line_axi_responder_pkg::*;
#(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned LineWidth = 128,
   parameter logic [63:0] MemBase   = 64'h8000_0000,
   parameter int unsigned MemWords  = 65536
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         aw_valid_i,
   output logic                         aw_ready_o,
   input  logic [IdWidth-1:0]           aw_id_i,
   input  logic [AddrWidth-1:0]         aw_addr_i,
   input  logic [7:0]                   aw_len_i,
   input  logic [2:0]                   aw_size_i,
   input  logic [1:0]                   aw_burst_i,
   input  logic                         w_valid_i,
   output logic                         w_ready_o,
   input  logic [DataWidth-1:0]         w_data_i,
   input  logic [DataWidth/8-1:0]       w_strb_i,
   input  logic                         w_last_i,
   output logic                         b_valid_o,
   input  logic                         b_ready_i,
   output logic [IdWidth-1:0]           b_id_o,
   output logic [1:0]                   b_resp_o,
   output logic                         mem_req_o,
   output logic [$clog2(MemWords)-1:0]  mem_addr_o,
   output logic [DataWidth-1:0]         mem_wdata_o,
   output logic [DataWidth/8-1:0]       mem_be_o
);

   localparam int unsigned BeatBytes = DataWidth / 8;
   localparam int unsigned ByteShift = $clog2(BeatBytes);
   localparam int unsigned IdxWidth  = $clog2(MemWords);
   localparam int unsigned MaxBeats  = LineWidth / DataWidth;
   localparam logic [63:0] MemBytes  = 64'(MemWords) * 64'(BeatBytes);

   state_e                r_state;
   logic                  r_awReady;
   logic                  r_wReady;
   logic                  r_bValid;
   logic [1:0]            r_bResp;
   logic [IdWidth-1:0]    r_id;
   logic [IdxWidth-1:0]   r_word;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic [1:0]            r_err;

   logic                  w_awFire;
   logic                  w_wFire;
   logic                  w_bFire;
   logic                  w_memReq;
   logic [IdxWidth-1:0]   w_awIdx;
   logic [1:0]            w_awErr;
   logic [1:0]            w_beatErr;

   assign w_awFire = aw_valid_i & r_awReady;
   assign w_wFire  = w_valid_i & r_wReady;
   assign w_bFire  = r_bValid & b_ready_i;

   // Word index relative to the memory base; sub-word address bits drop out
   // in the shift, and anything above the memory depth is truncated away.
   assign w_awIdx = IdxWidth'((64'(aw_addr_i) - MemBase) >> ByteShift);

   // Classify the incoming AW: an address outside the backing memory is a
   // decode error, which outranks any malformed-burst slave error.
   always_comb begin
      w_awErr = RESP_OKAY;
      if (!in_range(64'(aw_addr_i), MemBase, MemBytes)) begin
         w_awErr = RESP_DECERR;
      end else if ((aw_burst_i != BURST_INCR) ||
                   (aw_size_i != 3'(ByteShift)) ||
                   ((9'(aw_len_i) + 9'd1) > 9'(MaxBeats))) begin
         w_awErr = RESP_SLVERR;
      end
   end

   // Running response after the current beat. A last marker that does not
   // line up with the announced length downgrades an OKAY burst to SLVERR;
   // once not OKAY the code is sticky so later beats are never written.
   always_comb begin
      w_beatErr = r_err;
      if ((r_err == RESP_OKAY) && (w_last_i != (r_cnt == r_len))) begin
         w_beatErr = RESP_SLVERR;
      end
   end

   // SRAM writes are issued in the same cycle as the W handshake. The data
   // path is zeroed when no write happens so the port is quiet in reset.
   assign w_memReq    = rst_ni & w_wFire & (r_err == RESP_OKAY);
   assign mem_req_o   = w_memReq;
   assign mem_addr_o  = w_memReq ? (r_word + IdxWidth'(r_cnt)) : '0;
   assign mem_wdata_o = w_memReq ? w_data_i : '0;
   assign mem_be_o    = w_memReq ? w_strb_i : '0;

   assign aw_ready_o  = r_awReady;
   assign w_ready_o   = r_wReady;
   assign b_valid_o   = r_bValid;
   assign b_id_o      = r_id;
   assign b_resp_o    = r_bResp;

   // Transaction FSM. Handshake readies are registered, so AW is only
   // offered one cycle after reset release or after the B handshake.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_awReady <= 1'b0;
         r_wReady  <= 1'b0;
         r_bValid  <= 1'b0;
         r_bResp   <= RESP_OKAY;
         r_id      <= '0;
         r_word    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_err     <= RESP_OKAY;
      end else begin
         case (r_state)
            IDLE: begin
               r_awReady <= 1'b1;
               if (w_awFire) begin
                  r_awReady <= 1'b0;
                  r_wReady  <= 1'b1;
                  r_id      <= aw_id_i;
                  r_word    <= w_awIdx;
                  r_len     <= aw_len_i;
                  r_cnt     <= '0;
                  r_err     <= w_awErr;
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (w_wFire) begin
                  r_cnt <= r_cnt + 8'd1;
                  r_err <= w_beatErr;
                  if (w_last_i) begin
                     r_wReady <= 1'b0;
                     r_bValid <= 1'b1;
                     r_bResp  <= w_beatErr;
                     r_state  <= RESP;
                  end
               end
            end
            RESP: begin
               if (w_bFire) begin
                  r_bValid  <= 1'b0;
                  r_awReady <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_line_axi_responder.sv
// ---------------------------------------------------------------------------
// tb_wb_line_axi_responder
//   Directed and randomized bursts against the write-back line responder.
//   Expected SRAM writes and B responses come from a behavioural model of
//   the address window, burst legality and beat-count rules.
// ---------------------------------------------------------------------------
module tb_wb_line_axi_responder;

   localparam int          IdW   = 4;
   localparam int          AddrW = 64;
   localparam int          DataW = 64;
   localparam int          LineW = 128;
   localparam int          Words = 65536;
   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam logic [63:0] SPAN  = 64'(Words) * 64'(DataW / 8);

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               aw_valid_i = 1'b0;
   logic               aw_ready_o;
   logic [IdW-1:0]     aw_id_i = '0;
   logic [AddrW-1:0]   aw_addr_i = '0;
   logic [7:0]         aw_len_i = '0;
   logic [2:0]         aw_size_i = '0;
   logic [1:0]         aw_burst_i = '0;
   logic               w_valid_i = 1'b0;
   logic               w_ready_o;
   logic [DataW-1:0]   w_data_i = '0;
   logic [DataW/8-1:0] w_strb_i = '0;
   logic               w_last_i = 1'b0;
   logic               b_valid_o;
   logic               b_ready_i = 1'b0;
   logic [IdW-1:0]     b_id_o;
   logic [1:0]         b_resp_o;
   logic               mem_req_o;
   logic [15:0]        mem_addr_o;
   logic [DataW-1:0]   mem_wdata_o;
   logic [DataW/8-1:0] mem_be_o;

   int nChecks = 0;
   int nFails  = 0;

   wb_line_axi_responder #(
      .IdWidth   (IdW),
      .AddrWidth (AddrW),
      .DataWidth (DataW),
      .LineWidth (LineW),
      .MemBase   (BASE),
      .MemWords  (Words)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .aw_valid_i  (aw_valid_i),
      .aw_ready_o  (aw_ready_o),
      .aw_id_i     (aw_id_i),
      .aw_addr_i   (aw_addr_i),
      .aw_len_i    (aw_len_i),
      .aw_size_i   (aw_size_i),
      .aw_burst_i  (aw_burst_i),
      .w_valid_i   (w_valid_i),
      .w_ready_o   (w_ready_o),
      .w_data_i    (w_data_i),
      .w_strb_i    (w_strb_i),
      .w_last_i    (w_last_i),
      .b_valid_o   (b_valid_o),
      .b_ready_i   (b_ready_i),
      .b_id_o      (b_id_o),
      .b_resp_o    (b_resp_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk_i = ~clk_i;

   // Hard stop in case a handshake never completes.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Response the burst should earn: outside the window is a decode error;
   // wrong burst type, wrong beat size, a burst longer than a line, or a
   // beat count that disagrees with len is a slave error.
   function automatic logic [1:0] modelResp(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int nBeats);
      if (addr < BASE || addr >= BASE + SPAN) return 2'b11;
      if (burst != 2'b01 || size != 3'd3 || int'(len) + 1 > LineW / DataW) return 2'b10;
      if (nBeats != int'(len) + 1) return 2'b10;
      return 2'b00;
   endfunction

   // Word that beat k of a burst starting at addr lands on.
   function automatic logic [63:0] modelIdx(input logic [63:0] addr, input int k);
      return ((addr - BASE) / 64'd8 + 64'(k)) % 64'(Words);
   endfunction

   // Present an AW and wait (bounded) for the handshake; returns at the
   // falling edge after the handshake with aw_valid dropped.
   task automatic applyAw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
      ok = 1'b0;
      @(negedge clk_i);
      aw_valid_i = 1'b1;
      aw_id_i    = id;
      aw_addr_i  = addr;
      aw_len_i   = len;
      aw_size_i  = size;
      aw_burst_i = burst;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (aw_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      if (!ok) begin
         checkOutput("awReadyTimeout", 64'd0, 64'd1);
         aw_valid_i = 1'b0;
      end else begin
         @(posedge clk_i);
         @(negedge clk_i);
         aw_valid_i = 1'b0;
      end
   endtask

   // One full burst: AW, nBeats W beats (last on the final one), then B held
   // off for bHold cycles. strbFixed < 0 selects random strobes.
   task automatic applyStimulus(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input int nBeats,
                                input int bHold, input int strbFixed);
      bit          ok;
      logic [1:0]  expResp;
      bit          awOk;
      bit          expW;
      logic [63:0] data;
      logic [7:0]  strb;
      expResp = modelResp(addr, len, size, burst, nBeats);
      awOk    = (modelResp(addr, len, size, burst, int'(len) + 1) == 2'b00);
      applyAw(id, addr, len, size, burst, ok);
      if (ok) begin
         for (int k = 0; k < nBeats; k++) begin
            if (k > 0) @(negedge clk_i);
            data = {$urandom, $urandom};
            strb = (strbFixed < 0) ? 8'($urandom) : 8'(strbFixed);
            w_valid_i = 1'b1;
            w_data_i  = data;
            w_strb_i  = strb;
            w_last_i  = (k == nBeats - 1);
            #1;
            expW = awOk && (k <= int'(len));
            checkOutput("wReady", 64'(w_ready_o), 64'd1);
            checkOutput("memReq", 64'(mem_req_o), 64'(expW));
            if (expW) begin
               checkOutput("memAddr", 64'(mem_addr_o), modelIdx(addr, k));
               checkOutput("memWdata", mem_wdata_o, data);
               checkOutput("memBe", 64'(mem_be_o), 64'(strb));
            end
         end
         @(negedge clk_i);
         w_valid_i = 1'b0;
         w_last_i  = 1'b0;
         #1;
         checkOutput("bValid", 64'(b_valid_o), 64'd1);
         checkOutput("bId", 64'(b_id_o), 64'(id));
         checkOutput("bResp", 64'(b_resp_o), 64'(expResp));
         for (int h = 0; h < bHold; h++) begin
            @(negedge clk_i);
            #1;
            checkOutput("bValidHold", 64'(b_valid_o), 64'd1);
            checkOutput("bIdHold", 64'(b_id_o), 64'(id));
            checkOutput("bRespHold", 64'(b_resp_o), 64'(expResp));
            checkOutput("awReadyInResp", 64'(aw_ready_o), 64'd0);
         end
         @(negedge clk_i);
         b_ready_i = 1'b1;
         @(negedge clk_i);
         b_ready_i = 1'b0;
         #1;
         checkOutput("bValidAfterHs", 64'(b_valid_o), 64'd0);
         checkOutput("awReadyAfterB", 64'(aw_ready_o), 64'd1);
      end
   endtask

   initial begin
      bit          ok;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          nBeats;

      // Reset: everything quiet, AW ready only a cycle after release.
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      checkOutput("rstAwReady", 64'(aw_ready_o), 64'd0);
      checkOutput("rstWReady", 64'(w_ready_o), 64'd0);
      checkOutput("rstBValid", 64'(b_valid_o), 64'd0);
      checkOutput("rstMemReq", 64'(mem_req_o), 64'd0);
      checkOutput("rstBResp", 64'(b_resp_o), 64'd0);
      checkOutput("rstBId", 64'(b_id_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checkOutput("awReadyAtRelease", 64'(aw_ready_o), 64'd0);
      @(negedge clk_i);
      #1;
      checkOutput("awReadyAfterRelease", 64'(aw_ready_o), 64'd1);

      // W presented while idle must not be taken.
      w_valid_i = 1'b1;
      w_last_i  = 1'b1;
      w_data_i  = 64'hDEAD_BEEF_0000_0001;
      w_strb_i  = 8'hFF;
      #1;
      checkOutput("idleWReady", 64'(w_ready_o), 64'd0);
      checkOutput("idleMemReq", 64'(mem_req_o), 64'd0);
      @(negedge clk_i);
      #1;
      checkOutput("idleNoB", 64'(b_valid_o), 64'd0);
      w_valid_i = 1'b0;
      w_last_i  = 1'b0;

      // Directed bursts.
      applyStimulus(4'd3, 64'h8000_0040, 8'd1, 3'd3, 2'b01, 2, 0, -1);
      applyStimulus(4'd7, 64'h4000_0000, 8'd1, 3'd3, 2'b01, 2, 0, -1);
      applyStimulus(4'd1, 64'h8000_0100, 8'd1, 3'd3, 2'b01, 1, 0, -1);
      applyStimulus(4'd2, 64'h8000_0200, 8'd3, 3'd3, 2'b01, 4, 0, -1);
      applyStimulus(4'd9, 64'h8000_1000, 8'd0, 3'd3, 2'b01, 3, 0, -1);
      applyStimulus(4'd5, 64'h8000_0300, 8'd1, 3'd3, 2'b01, 2, 5, -1);
      applyStimulus(4'd6, 64'h8000_0000 + 64'd65535 * 64'd8, 8'd1, 3'd3, 2'b01, 2, 0, 8'h0F);
      applyStimulus(4'd4, 64'h8000_0045, 8'd0, 3'd3, 2'b01, 1, 1, -1);
      applyStimulus(4'd8, BASE + SPAN, 8'd0, 3'd3, 2'b01, 1, 0, -1);
      applyStimulus(4'd10, BASE - 64'd1, 8'd0, 3'd3, 2'b01, 1, 0, -1);
      applyStimulus(4'd11, 64'h8000_0400, 8'd0, 3'd2, 2'b01, 1, 0, -1);
      applyStimulus(4'd12, 64'h8000_0400, 8'd0, 3'd3, 2'b10, 1, 0, -1);

      // Reset one cycle after the first beat: no B, outputs cleared.
      applyAw(4'd13, 64'h8000_0800, 8'd1, 3'd3, 2'b01, ok);
      if (ok) begin
         w_valid_i = 1'b1;
         w_last_i  = 1'b0;
         w_data_i  = 64'h1234_5678_9ABC_DEF0;
         w_strb_i  = 8'hFF;
         #1;
         checkOutput("preRstMemReq", 64'(mem_req_o), 64'd1);
         checkOutput("preRstMemAddr", 64'(mem_addr_o), 64'd256);
         @(negedge clk_i);
         rst_ni   = 1'b0;
         w_last_i = 1'b1;
         #1;
         checkOutput("inRstMemReq", 64'(mem_req_o), 64'd0);
         @(negedge clk_i);
         rst_ni    = 1'b1;
         w_valid_i = 1'b0;
         w_last_i  = 1'b0;
         #1;
         checkOutput("midRstBValid", 64'(b_valid_o), 64'd0);
         checkOutput("midRstWReady", 64'(w_ready_o), 64'd0);
         checkOutput("midRstAwReady", 64'(aw_ready_o), 64'd0);
         checkOutput("midRstBId", 64'(b_id_o), 64'd0);
         @(negedge clk_i);
         #1;
         checkOutput("midRstNoB", 64'(b_valid_o), 64'd0);
         checkOutput("midRstAwReadyBack", 64'(aw_ready_o), 64'd1);
      end
      applyStimulus(4'd14, 64'h8000_0800, 8'd1, 3'd3, 2'b01, 2, 0, -1);

      // Randomized bursts.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 9))
            0:       addr = BASE + SPAN + 64'($urandom_range(0, 4095));
            1:       addr = BASE - 64'($urandom_range(1, 4096));
            default: addr = BASE + 64'($urandom_range(0, Words - 1)) * 64'd8
                                 + 64'($urandom_range(0, 7));
         endcase
         len    = 8'($urandom_range(0, 2));
         size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
         burst  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         nBeats = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : int'(len) + 1;
         applyStimulus(4'($urandom), addr, len, size, burst, nBeats, $urandom_range(0, 3), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
